// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//   Scans a 4-digit common-anode 7-segment display. Shows sec.msec (disp_sel=0)
//   or hour.min (disp_sel=1) as two decimal pairs, leading zeros kept. The dp of
//   digit 2 is lit while msec < 50, giving a half-second blink.
//
//   Optional macro FND_BLINK_EN: while setting=1 the field named by status
//   (1 sec, 2 min, 3 hour) blanks during the off phase of a blink counter, but
//   only when that field is currently displayed. Without the macro setting and
//   status are ignored and no blink counter exists.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   msec      in   [6:0] hundredths 0..99
//   sec       in   [5:0] seconds 0..59
//   min       in   [5:0] minutes 0..59
//   hour      in   [5:0] hours 0..23
//   disp_sel  in   0: sec.msec, 1: hour.min
//   setting   in   time-setting mode active
//   status    in   [1:0] field under edit: 0 none, 1 sec, 2 min, 3 hour
//   fnd_com   out  [3:0] digit enables, active-low, bit0 = rightmost digit
//   fnd_data  out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low
module fnd_scan_controller #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [5:0] hour,
   input  logic       disp_sel,
   input  logic       setting,
   input  logic [1:0] status,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int unsigned ScanDiv = CLK_FREQ / SCAN_HZ;
   localparam int unsigned ScanW   = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
   localparam logic [ScanW-1:0] ScanMax = ScanW'(ScanDiv - 1);

   // 7-bit segment code {g,f,e,d,c,b,a}, active-low; anything above 9 is blank.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] sat99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       fnd_com_q, fnd_com_d;
   logic [7:0]       fnd_data_q, fnd_data_d;
   logic             scan_tick;
   logic [6:0]       low_val, high_val;
   logic [3:0]       digit;
   logic             dp_n;
   logic             blank;

`ifdef FND_BLINK_EN
   localparam int unsigned BlinkDiv = CLK_FREQ / (2 * BLINK_HZ);
   localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
   localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkDiv - 1);

   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
      blink_on_d  = blink_on_q;
      if (blink_cnt_q == BlinkMax) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end

   // The edited field blanks only when it is the pair on screen; idx_q[1]
   // separates the low pair (d0,d1) from the high pair (d2,d3).
   always_comb begin
      blank = 1'b0;
      if (setting && !blink_on_q) begin
         case (status)
            2'd1:    blank = !disp_sel &&  idx_q[1];
            2'd2:    blank =  disp_sel && !idx_q[1];
            2'd3:    blank =  disp_sel &&  idx_q[1];
            default: blank = 1'b0;
         endcase
      end
   end
`else
   localparam int unsigned unused_blink_hz = BLINK_HZ;
   logic unused_inputs;
   assign unused_inputs = ^{setting, status};
   assign blank = 1'b0;
`endif

   always_comb begin
      scan_tick  = (scan_cnt_q == ScanMax);
      scan_cnt_d = scan_tick ? '0 : scan_cnt_q + ScanW'(1);
      idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;

      low_val  = sat99(disp_sel ? {1'b0, min}  : msec);
      high_val = sat99(disp_sel ? {1'b0, hour} : {1'b0, sec});

      digit = 4'd0;
      dp_n  = 1'b1;
      unique case (idx_q)
         2'd0: digit = 4'(low_val % 7'd10);
         2'd1: digit = 4'(low_val / 7'd10);
         2'd2: begin
            digit = 4'(high_val % 7'd10);
            dp_n  = (msec >= 7'd50);
         end
         2'd3: digit = 4'(high_val / 7'd10);
         default: digit = 4'd0;
      endcase

      fnd_com_d  = ~(4'b0001 << idx_q);
      fnd_data_d = blank ? 8'hFF : {dp_n, seg_code(digit)};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt_q <= '0;
         idx_q      <= 2'd0;
         fnd_com_q  <= 4'b1111;
         fnd_data_q <= 8'hFF;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         fnd_com_q  <= fnd_com_d;
         fnd_data_q <= fnd_data_d;
      end
   end

   assign fnd_com  = fnd_com_q;
   assign fnd_data = fnd_data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller with CLK_FREQ=100, SCAN_HZ=10, BLINK_HZ=5:
// the digit advances and the blink phase toggles every 10 clocks.
// Expectations are tagged with the posedge count since reset release and are
// checked by a separate monitor at the following negedge.
module tb_fnd_scan_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] msec = 7'd5;
   logic [5:0] sec = 6'd37;
   logic [5:0] min = 6'd34;
   logic [5:0] hour = 6'd12;
   logic       disp_sel = 1'b0;
   logic       setting = 1'b0;
   logic [1:0] status = 2'd0;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int total = 0;
   int bad = 0;
   int edges;

`ifdef FND_BLINK_EN
   localparam bit BlinkEn = 1'b1;
`else
   localparam bit BlinkEn = 1'b0;
`endif

   typedef struct {
      int         n;
      logic [3:0] com;
      logic [7:0] data;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   fnd_scan_controller #(
      .CLK_FREQ(100),
      .SCAN_HZ (10),
      .BLINK_HZ(5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .msec    (msec),
      .sec     (sec),
      .min     (min),
      .hour    (hour),
      .disp_sel(disp_sel),
      .setting (setting),
      .status  (status),
      .fnd_com (fnd_com),
      .fnd_data(fnd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) edges <= 0;
      else        edges <= edges + 1;
   end

   task automatic check(input string name, input logic [3:0] com_exp,
                        input logic [7:0] data_exp);
      total++;
      if (fnd_com !== com_exp || fnd_data !== data_exp) begin
         bad++;
         $display("FAIL %s: got com=%b data=%h, want com=%b data=%h (t=%0t)",
                  name, fnd_com, fnd_data, com_exp, data_exp, $time);
      end
   endtask

   task automatic push(input int n, input logic [3:0] com, input logic [7:0] data,
                       input string name);
      exp_t x;
      x.n = n; x.com = com; x.data = data; x.name = name;
      sb.push_back(x);
   endtask

   // Returns 2 time units after the negedge that follows posedge n.
   task automatic wait_edges(input int n);
      do @(negedge clk); while (edges < n);
      #2;
   endtask

   // Monitor: compare the head expectation when its edge count comes round.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         if (sb[0].n == edges) begin
            e = sb.pop_front();
            check(e.name, e.com, e.data);
         end else if (sb[0].n < edges) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for edge %0d missed at edge %0d",
                     e.name, e.n, edges);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset held, then release; sec.msec = 37.05
      push(0, 4'b1111, 8'hFF, "reset_hold");
      repeat (3) @(negedge clk);
      #2;
      push(1,  4'b1110, 8'h92, "d0_msec_ones5");
      push(10, 4'b1110, 8'h92, "d0_last_cycle");
      push(11, 4'b1101, 8'hC0, "d1_msec_tens0");
      push(21, 4'b1011, 8'h78, "d2_sec_ones7_dp");
      push(31, 4'b0111, 8'hB0, "d3_sec_tens3");
      push(41, 4'b1110, 8'h92, "d0_wrap");
      push(62, 4'b1011, 8'h78, "d2_before_switch");
      reset = 1'b1;

      // ---- mode switch while digit 2 is on screen
      wait_edges(62);
      disp_sel = 1'b1;
      push(63, 4'b1011, 8'h24, "switch_d2_hour2_dp");
      push(71, 4'b0111, 8'hF9, "d3_hour_tens1");
      push(81, 4'b1110, 8'h99, "d0_min_ones4");
      push(91, 4'b1101, 8'hB0, "d1_min_tens3");

      // ---- dp boundary at msec 49/50
      wait_edges(95);
      msec = 7'd49;
      push(101, 4'b1011, 8'h24, "dp_msec49_lit");
      wait_edges(102);
      msec = 7'd50;
      push(103, 4'b1011, 8'hA4, "dp_msec50_off");
      push(111, 4'b0111, 8'hF9, "d3_dp_off");
      wait_edges(112);
      msec = 7'd49;
      push(121, 4'b1110, 8'h99, "d0_dp_off_msec49");

      // ---- saturation of an out-of-range field
      wait_edges(122);
      disp_sel = 1'b0;
      msec = 7'd120;
      push(123, 4'b1110, 8'h90, "sat_d0_9");
      push(131, 4'b1101, 8'h90, "sat_d1_9");
      push(141, 4'b1011, 8'hF8, "sat_d2_dp_off");

      // ---- asynchronous reset between clock edges
      wait_edges(142);
      reset = 1'b0;
      #1;
      check("async_reset", 4'b1111, 8'hFF);

      // ---- field blink: editing min while hour.min is shown
      repeat (2) @(negedge clk);
      #2;
      msec = 7'd5;
      disp_sel = 1'b1;
      setting = 1'b1;
      status = 2'd2;
      push(1,  4'b1110, 8'h99, "blink_d0_phase_on");
      push(11, 4'b1101, BlinkEn ? 8'hFF : 8'hB0, "blink_d1_phase_off");
      push(15, 4'b1101, BlinkEn ? 8'hFF : 8'hB0, "blink_d1_mid");
      push(21, 4'b1011, 8'h24, "blink_d2_steady");
      push(31, 4'b0111, 8'hF9, "blink_d3_steady");
      push(51, 4'b1101, BlinkEn ? 8'hFF : 8'hB0, "blink_d1_again");
      reset = 1'b1;

      wait_edges(52);
      disp_sel = 1'b0;
      push(53, 4'b1101, 8'hC0, "min_edit_not_shown");
      wait_edges(54);
      disp_sel = 1'b1;
      setting = 1'b0;
      push(55, 4'b1101, 8'hB0, "setting_off_unblank");
      push(56, 4'b1101, 8'hB0, "setting_off_hold");

      // ---- editing sec while sec.msec is shown
      wait_edges(56);
      setting = 1'b1;
      status = 2'd1;
      disp_sel = 1'b0;
      push(61, 4'b1011, 8'h78, "sec_edit_phase_on");
      push(71, 4'b0111, BlinkEn ? 8'hFF : 8'hB0, "sec_edit_phase_off");
      push(91, 4'b1101, 8'hC0, "msec_never_blinks");

      wait_edges(95);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL %s: expectation for edge %0d never checked", e.name, e.n);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
